// File: rtl/ffq_winner_decoder.sv
// -----------------------------------------------------------------------------
// ffq_winner_decoder
//
// Receive end of the quiz buzzer path. It takes the contestant code from the
// priority encoder, debounces and validates it, and locks the first valid
// winner of the round. While a winner is locked it drives a one-hot lamp bus,
// a timed buzzer pulse and a blink phase. The result is held until the
// quizmaster clears the round. The decoder then re-arms only after every
// button has been released.
//
// Ports
//   clk            : system clock, all logic on the rising edge
//   reset          : synchronous, active-high reset
//   code_in[3:0]   : encoder output, 0 = no press, 1..NUM_PLAYERS = contestant
//   clear          : quizmaster round clear, level-sampled
//   winner_onehot  : bit (id-1) set while a winner is locked
//   winner_id[3:0] : locked contestant number, 0 when none
//   locked         : high from lock until clear or reset
//   buzzer         : high for exactly BUZZ_CYCLES cycles after lock
//   blink          : lamp flash phase, 0 when not locked
//   code_err       : one-cycle pulse per IDLE edge that sees an out-of-range code
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module ffq_winner_decoder #(
    parameter int NUM_PLAYERS     = 10,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int BUZZ_CYCLES     = 8,
    parameter int BLINK_HALF      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             code_in,
    input  logic                   clear,
    output logic [NUM_PLAYERS-1:0] winner_onehot,
    output logic [3:0]             winner_id,
    output logic                   locked,
    output logic                   buzzer,
    output logic                   blink,
    output logic                   code_err
);

    // Counter widths are sized so that the largest value each counter holds
    // fits, with a floor of one bit.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BZ_W  = $clog2(BUZZ_CYCLES + 1);
    localparam int BL_W  = $clog2(BLINK_HALF + 1);

    localparam logic [3:0]       MAX_CODE   = 4'(NUM_PLAYERS);
    localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [BZ_W-1:0]  BUZZ_LAST  = BZ_W'(BUZZ_CYCLES - 1);
    localparam logic [BL_W-1:0]  BLINK_LAST = BL_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_REARM = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUZZ  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             last_code_q, last_code_d;
    logic [BZ_W-1:0]        buzz_cnt_q, buzz_cnt_d;
    logic [BL_W-1:0]        blink_cnt_q, blink_cnt_d;
    logic [NUM_PLAYERS-1:0] onehot_q, onehot_d;
    logic [3:0]             id_q, id_d;
    logic                   locked_q, locked_d;
    logic                   buzzer_q, buzzer_d;
    logic                   blink_q, blink_d;
    logic                   code_err_q, code_err_d;

    // -------------------------------------------------------------------------
    // Code classification and one-hot decode of the incoming code
    // -------------------------------------------------------------------------
    logic                   code_valid;
    logic                   code_invalid;
    logic [NUM_PLAYERS-1:0] code_dec;

    assign code_valid   = (code_in != 4'd0) && (code_in <= MAX_CODE);
    assign code_invalid = (code_in > MAX_CODE);

    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_dec
            localparam logic [3:0] GI_CODE = 4'(gi + 1);
            assign code_dec[gi] = (code_in == GI_CODE);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Stability count as it would be after this edge. An invalid code or 0
    // breaks the run. A new valid code starts a fresh run at 1.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_upd;
    logic             lock_now;

    always_comb begin
        cnt_upd = '0;
        if (code_valid && (code_in == last_code_q)) begin
            cnt_upd = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (code_valid) begin
            cnt_upd = CNT_W'(1);
        end
    end

    // A clear in IDLE suppresses the lock on that edge.
    assign lock_now = code_valid && (cnt_upd == DEB_MAX) && !clear;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_code_d = last_code_q;
        buzz_cnt_d  = buzz_cnt_q;
        blink_cnt_d = blink_cnt_q;
        onehot_d    = onehot_q;
        id_d        = id_q;
        locked_d    = locked_q;
        buzzer_d    = buzzer_q;
        blink_d     = blink_q;
        code_err_d  = 1'b0;

        case (state_q)
            ST_REARM: begin
                // Any code still held from the last round is ignored here.
                // Only a full release moves on, so a stuck button cannot win.
                cnt_d       = '0;
                last_code_d = 4'd0;
                if (code_in == 4'd0) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                cnt_d       = clear ? '0 : cnt_upd;
                last_code_d = code_in;
                code_err_d  = code_invalid;
                if (lock_now) begin
                    state_d     = ST_BUZZ;
                    id_d        = code_in;
                    onehot_d    = code_dec;
                    locked_d    = 1'b1;
                    buzzer_d    = 1'b1;
                    blink_d     = 1'b1;
                    buzz_cnt_d  = '0;
                    blink_cnt_d = '0;
                    cnt_d       = '0;
                    last_code_d = 4'd0;
                end
            end

            ST_BUZZ, ST_HOLD: begin
                if (clear) begin
                    state_d     = ST_REARM;
                    cnt_d       = '0;
                    last_code_d = 4'd0;
                    buzz_cnt_d  = '0;
                    blink_cnt_d = '0;
                    onehot_d    = '0;
                    id_d        = 4'd0;
                    locked_d    = 1'b0;
                    buzzer_d    = 1'b0;
                    blink_d     = 1'b0;
                end else begin
                    // The blink phase runs from the lock edge without a break
                    // at the BUZZ to HOLD transition.
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BL_W'(1);
                    end

                    if (state_q == ST_BUZZ) begin
                        // The lock edge was the first buzzer-high cycle.
                        if (buzz_cnt_q == BUZZ_LAST) begin
                            buzzer_d   = 1'b0;
                            buzz_cnt_d = '0;
                            state_d    = ST_HOLD;
                        end else begin
                            buzz_cnt_d = buzz_cnt_q + BZ_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = ST_REARM;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_REARM;
            cnt_q       <= '0;
            last_code_q <= 4'd0;
            buzz_cnt_q  <= '0;
            blink_cnt_q <= '0;
            onehot_q    <= '0;
            id_q        <= 4'd0;
            locked_q    <= 1'b0;
            buzzer_q    <= 1'b0;
            blink_q     <= 1'b0;
            code_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_code_q <= last_code_d;
            buzz_cnt_q  <= buzz_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            onehot_q    <= onehot_d;
            id_q        <= id_d;
            locked_q    <= locked_d;
            buzzer_q    <= buzzer_d;
            blink_q     <= blink_d;
            code_err_q  <= code_err_d;
        end
    end

    assign winner_onehot = onehot_q;
    assign winner_id     = id_q;
    assign locked        = locked_q;
    assign buzzer        = buzzer_q;
    assign blink         = blink_q;
    assign code_err      = code_err_q;

endmodule

// File: doc/ffq_winner_decoder.md
Name: ffq_winner_decoder

Overview:
- Receive end of the quiz buzzer path: takes the 4-bit contestant code from the priority encoder (0 = no press, 1..10 = contestant number) and turns it into the round's locked winner.
- Debounces and validates the code, latches the first valid winner, and drives a one-hot winner lamp bus, a timed buzzer pulse and a blink phase.
- Holds the result until the quizmaster clears the round, then re-arms only after all buttons are released.

Parameters:
- NUM_PLAYERS, 10: number of contestants. Valid codes are 1..NUM_PLAYERS; max 15.
- DEBOUNCE_CYCLES, 2: consecutive edges that must sample the same valid code before lock; min 1.
- BUZZ_CYCLES, 8: buzzer-high duration in clk cycles; min 1.
- BLINK_HALF, 4: blink half-period in clk cycles; min 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- code_in  input  4  encoder output; 0 = none, 1..NUM_PLAYERS = contestant.
- clear  input  1  quizmaster round clear; level-sampled.
- winner_onehot  output  NUM_PLAYERS  bit (id-1) high while a winner is locked.
- winner_id  output  4  locked contestant number; 0 when none.
- locked  output  1  high from lock until clear or reset.
- buzzer  output  1  high for exactly BUZZ_CYCLES cycles after lock.
- blink  output  1  lamp flash phase; 0 when not locked.
- code_err  output  1  one-cycle pulse per IDLE edge that samples a code greater than NUM_PLAYERS.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port names are clk and reset.
- All outputs are registered.
- Reset:
  - All outputs go to 0, the stability counter and last-code register clear, and the state goes to REARM.
  - Reset dominates clear and every other input on the same edge.
- States: REARM, IDLE, BUZZ, HOLD.
- REARM:
  - Waits for code_in == 0 on an edge; that edge moves to IDLE.
  - Nonzero codes, including invalid ones, are ignored: no code_err, no lock.
  - Purpose: a button still held across a clear or reset cannot win the next round.
- IDLE stability tracking, per edge:
  - If code_in is valid and equals last_code, cnt increments (saturating).
  - If code_in is valid but differs from last_code, cnt = 1.
  - If code_in is 0 or invalid, cnt = 0.
  - last_code <= code_in every edge.
- Lock:
  - On the edge where the updated cnt reaches DEBOUNCE_CYCLES, outputs update on that same edge: winner_id = code_in, winner_onehot = 1 << (code_in-1), locked = 1, buzzer = 1, blink = 1, buzz counter and blink counter = 0, state = BUZZ.
  - With DEBOUNCE_CYCLES = 2, a code present for two consecutive edges is locked at the second edge.
- Invalid code (code_in > NUM_PLAYERS) in IDLE: code_err = 1 for that cycle and cnt = 0. code_err is 0 in every other state.
- BUZZ:
  - code_in is ignored.
  - buzzer stays 1 for exactly BUZZ_CYCLES cycles, then drops to 0 and the state moves to HOLD.
  - Other outputs are held.
- HOLD: code_in is ignored; outputs are held except blink.
- Blink: while locked, blink toggles every BLINK_HALF cycles, counted from the lock edge, continuously across BUZZ and HOLD. Lamp driver = winner_onehot AND blink (external).
- clear:
  - Sampled high in BUZZ or HOLD: at that edge all outputs go to 0 (buzzer drops mid-pulse), counters clear, and the state goes to REARM.
  - Sampled high in IDLE: cnt = 0 and lock is suppressed on that edge.
  - Sampled high in REARM: no effect.
- Code changes after lock never alter winner_id or winner_onehot.
- Exactly one bit of winner_onehot is set while locked; all zero otherwise.

Test Plan:
- Reset then arm: reset 2 cycles with code_in = 0; then code_in = 3 for 2 edges -> locked = 1, winner_id = 3, winner_onehot = 0x004, buzzer high exactly 8 cycles, blink toggling every 4 cycles.
- Glitch rejection: code_in = 5 for 1 edge, then 7 for 2 edges -> winner_id = 7, winner_onehot = 0x040; no lock with id 5.
- Invalid code: code_in = 12 for 3 edges in IDLE -> code_err pulses on each edge, locked stays 0; then code_in = 10 for 2 edges -> winner_onehot = 0x200.
- Later press ignored: lock on 2, then code_in = 1 held 20 cycles -> winner_id stays 2, code_err never asserts.
- Clear mid-buzz and re-arm: lock on 4, clear at the 3rd buzz cycle -> next edge all outputs 0; code_in held at 4 -> stays REARM with no lock; code_in = 0 for one edge then 6 for 2 edges -> winner_id = 6.
- Reset during HOLD with clear also high -> all outputs 0 on that edge, state REARM; a held code_in = 9 does not lock until released.
